// File: rtl/modiff_stream.sv
// Streaming MODIFF pitch engine: fills a W+MAX_TAU sample frame, then emits d(tau) per lag and the minimising lag.
// Latency: d(k) at T0+(k-MIN_TAU+1)*W+1, done at T0+(MAX_TAU-MIN_TAU+1)*W+2 after the first COMPUTE cycle T0.
// Backpressure: s_ready is registered and high only in FILL; outputs are pulses with no downstream stall.
// Optional: define MODIFF_SQUARED_EN for a squared-difference term (multiplier in stage 2, same latency).
module modiff_stream #(
   parameter int DATA_WIDTH       = 8,
   parameter int WINDOW_SIZE_BITS = 8,
   parameter int MIN_TAU          = 2,
   parameter int MAX_TAU          = 40,
   parameter int TAU_WIDTH        = 6,
`ifdef MODIFF_SQUARED_EN
   parameter int ACC_WIDTH        = 2*DATA_WIDTH + WINDOW_SIZE_BITS
`else
   parameter int ACC_WIDTH        = DATA_WIDTH + WINDOW_SIZE_BITS
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   input  logic                  flush,
   output logic                  busy,
   output logic                  d_valid,
   output logic [TAU_WIDTH-1:0]  d_tau,
   output logic [ACC_WIDTH-1:0]  d_value,
   output logic                  done,
   output logic [TAU_WIDTH-1:0]  best_tau,
   output logic [ACC_WIDTH-1:0]  best_diff
);

   localparam int W      = 1 << WINDOW_SIZE_BITS;
   localparam int N      = W + MAX_TAU;
   localparam int ADDR_W = $clog2(N);
`ifdef MODIFF_SQUARED_EN
   localparam int TERM_W = 2*DATA_WIDTH;
`else
   localparam int TERM_W = DATA_WIDTH;
`endif

   typedef enum logic [1:0] {ST_FILL, ST_COMPUTE, ST_REPORT} state_t;

   state_t                  state, state_nxt;
   logic [DATA_WIDTH-1:0]   mem [N];
   logic [ADDR_W-1:0]       wr_idx;
   logic                    accept, wr_last;

   logic                        iss_act;
   logic [WINDOW_SIZE_BITS-1:0] iss_n;
   logic [TAU_WIDTH-1:0]        iss_tau;
   logic                        iss_last;
   logic [ADDR_W-1:0]           rd_a, rd_b;

   logic                  s1_vld, s1_first, s1_last;
   logic [TAU_WIDTH-1:0]  s1_tau;
   logic [DATA_WIDTH-1:0] s1_a, s1_b;

   logic [DATA_WIDTH-1:0] abs_diff;
   logic [TERM_W-1:0]     term;
   logic [ACC_WIDTH-1:0]  acc, acc_sum;
   logic [ACC_WIDTH-1:0]  run_min;
   logic [TAU_WIDTH-1:0]  run_tau;
   logic                  last_lag_out;

   assign accept       = s_valid && s_ready;
   assign wr_last      = accept && (wr_idx == ADDR_W'(N-1));
   assign iss_last     = (iss_n == {WINDOW_SIZE_BITS{1'b1}});
   assign rd_a         = ADDR_W'(iss_n);
   assign rd_b         = ADDR_W'(iss_n) + ADDR_W'(iss_tau);
   assign last_lag_out = d_valid && (d_tau == TAU_WIDTH'(MAX_TAU));
   assign busy         = (state == ST_COMPUTE);

   // Stage-2 arithmetic: per-sample term and running sum, cleared at n=0 of each lag.
   always_comb begin
      abs_diff = (s1_a > s1_b) ? (s1_a - s1_b) : (s1_b - s1_a);
`ifdef MODIFF_SQUARED_EN
      term     = TERM_W'(abs_diff) * TERM_W'(abs_diff);
`else
      term     = abs_diff;
`endif
      acc_sum  = (s1_first ? '0 : acc) + ACC_WIDTH'(term);
   end

   // Next-state: fill until the frame is full, compute until the last lag is out, report once; flush overrides.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_FILL:    if (wr_last) state_nxt = ST_COMPUTE;
         ST_COMPUTE: if (last_lag_out) state_nxt = ST_REPORT;
         ST_REPORT:  state_nxt = ST_FILL;
         default:    state_nxt = ST_FILL;
      endcase
      if (flush) state_nxt = ST_FILL;
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_FILL;
      else        state <= state_nxt;
   end

   // Write index and registered ready; index restarts whenever we leave or abort FILL.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_idx  <= '0;
         s_ready <= 1'b0;
      end else begin
         s_ready <= (state_nxt == ST_FILL);
         if (flush || state != ST_FILL || wr_last) wr_idx <= '0;
         else if (accept)                         wr_idx <= wr_idx + 1'b1;
      end
   end

   // Frame buffer write; contents need no reset since every frame refills it from index 0.
   always_ff @(posedge clk) begin
      if (accept && !flush) mem[wr_idx] <= s_data;
   end

   // Issue counters: walk n fastest, tau ascending, one read pair per cycle starting at T0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         iss_act <= 1'b0;
         iss_n   <= '0;
         iss_tau <= TAU_WIDTH'(MIN_TAU);
      end else if (state != ST_COMPUTE || flush) begin
         iss_act <= (state_nxt == ST_COMPUTE);
         iss_n   <= '0;
         iss_tau <= TAU_WIDTH'(MIN_TAU);
      end else if (iss_act) begin
         if (iss_last) begin
            iss_n <= '0;
            if (iss_tau == TAU_WIDTH'(MAX_TAU)) iss_act <= 1'b0;
            else                               iss_tau <= iss_tau + 1'b1;
         end else begin
            iss_n <= iss_n + 1'b1;
         end
      end
   end

   // Stage 1: fetch x[n] and x[n+tau] with the position tags that travel alongside.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_vld   <= 1'b0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
         s1_tau   <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else begin
         s1_vld   <= iss_act && !flush;
         s1_first <= (iss_n == '0);
         s1_last  <= iss_last;
         s1_tau   <= iss_tau;
         s1_a     <= mem[rd_a];
         s1_b     <= mem[rd_b];
      end
   end

   // Stage 2: accumulate, publish d(tau) at the lag's last sample, and track the strict running minimum.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc     <= '0;
         d_valid <= 1'b0;
         d_tau   <= '0;
         d_value <= '0;
         run_min <= '0;
         run_tau <= '0;
      end else if (flush) begin
         d_valid <= 1'b0;
      end else begin
         d_valid <= s1_vld && s1_last;
         if (s1_vld) begin
            acc <= acc_sum;
            if (s1_last) begin
               d_tau   <= s1_tau;
               d_value <= acc_sum;
               if (s1_tau == TAU_WIDTH'(MIN_TAU) || acc_sum < run_min) begin
                  run_min <= acc_sum;
                  run_tau <= s1_tau;
               end
            end
         end
      end
   end

   // Report: one-cycle done with the frame minimum latched alongside it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done      <= 1'b0;
         best_tau  <= '0;
         best_diff <= '0;
      end else begin
         done <= (state == ST_COMPUTE) && (state_nxt == ST_REPORT);
         if (state == ST_COMPUTE && state_nxt == ST_REPORT) begin
            best_tau  <= run_tau;
            best_diff <= run_min;
         end
      end
   end

endmodule

// File: tb/tb_modiff_stream.sv
// Scoreboard bench for modiff_stream: stimulus pushes model results, a negedge monitor pops and compares.
// Timing of every d_valid and done is checked relative to the first busy cycle.
// Covers ramp/constant/alternating/random frames, gaps, held valid, flush and mid-frame reset.
module tb_modiff_stream;

   localparam int DW   = 8;
   localparam int WSB  = 4;
   localparam int W    = 16;
   localparam int MINT = 2;
   localparam int MAXT = 8;
   localparam int TW   = 6;
   localparam int N    = W + MAXT;
   localparam int L    = MAXT - MINT + 1;
`ifdef MODIFF_SQUARED_EN
   localparam int AW   = 2*DW + WSB;
`else
   localparam int AW   = DW + WSB;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_ready;
   logic          flush = 1'b0;
   logic          busy;
   logic          d_valid;
   logic [TW-1:0] d_tau;
   logic [AW-1:0] d_value;
   logic          done;
   logic [TW-1:0] best_tau;
   logic [AW-1:0] best_diff;

   modiff_stream #(
      .DATA_WIDTH(DW), .WINDOW_SIZE_BITS(WSB), .MIN_TAU(MINT),
      .MAX_TAU(MAXT), .TAU_WIDTH(TW), .ACC_WIDTH(AW)
   ) dut (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .flush(flush), .busy(busy), .d_valid(d_valid), .d_tau(d_tau), .d_value(d_value),
      .done(done), .best_tau(best_tau), .best_diff(best_diff)
   );

   always #5 clk = ~clk;

   typedef struct {
      int     tau;
      longint val;
      int     rel;
   } exp_t;

   exp_t          exp_d[$];
   exp_t          exp_done[$];
   exp_t          me;
   logic [DW-1:0] frame [N];
   int            checks = 0;
   int            passes = 0;
   int            cyc = 0;
   int            t0 = 0;
   logic          prev_busy = 1'b0;

   task automatic check(input string name, input longint got, input longint want);
      checks++;
      if (got == want) passes++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, want);
   endtask

   task automatic fail_now(input string name);
      checks++;
      $display("FAIL %s: event observed/missing contrary to expectation", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: d(k) summed over the window straight from the definition, strict-less minimum.
   task automatic push_exp();
      longint d;
      longint best_v;
      int     best_t;
      best_v = 0;
      best_t = 0;
      for (int k = MINT; k <= MAXT; k++) begin
         d = 0;
         for (int n = 0; n < W; n++) begin
            longint df = longint'(frame[n]) - longint'(frame[n+k]);
`ifdef MODIFF_SQUARED_EN
            d += df * df;
`else
            d += (df < 0) ? -df : df;
`endif
         end
         exp_d.push_back('{k, d, (k - MINT + 1) * W + 1});
         if (k == MINT || d < best_v) begin
            best_v = d;
            best_t = k;
         end
      end
      exp_done.push_back('{best_t, best_v, L * W + 2});
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops the scoreboard whenever the DUT presents d_valid or done.
   always @(negedge clk) begin
      if (!reset) begin
         prev_busy = 1'b0;
      end else begin
         if (busy && !prev_busy) t0 = cyc;
         prev_busy = busy;
         if (busy) check("s_ready_low_while_busy", s_ready, 0);
         if (d_valid) begin
            if (exp_d.size() == 0) fail_now("unexpected_d_valid");
            else begin
               me = exp_d.pop_front();
               check("d_tau", d_tau, me.tau);
               check("d_value", d_value, me.val);
               check("d_valid_cycle", cyc - t0, me.rel);
            end
         end
         if (done) begin
            if (exp_done.size() == 0) fail_now("unexpected_done");
            else begin
               me = exp_done.pop_front();
               check("best_tau", best_tau, me.tau);
               check("best_diff", best_diff, me.val);
               check("done_cycle", cyc - t0, me.rel);
            end
         end
      end
   end

   task automatic send_frame(input bit gaps, input bit hold);
      int i = 0;
      int guard = 0;
      push_exp();
      while (i < N && guard < 2000) begin
         s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         s_data  = s_valid ? frame[i] : DW'($urandom);
         if (s_valid && s_ready) i++;
         tick();
         guard++;
      end
      if (i < N) fail_now("fill_timeout");
      s_valid = hold;
      s_data  = DW'($urandom);
   endtask

   task automatic wait_done();
      int c = 0;
      while (!done && c < 300) begin
         tick();
         c++;
      end
      if (!done) fail_now("done_timeout");
      s_valid = 1'b0;
      tick();
   endtask

   task automatic clear_exp();
      exp_d.delete();
      exp_done.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_s_ready"}, s_ready, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_d_valid"}, d_valid, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_d_tau"}, d_tau, 0);
      check({tag, "_d_value"}, d_value, 0);
      check({tag, "_best_tau"}, best_tau, 0);
      check({tag, "_best_diff"}, best_diff, 0);
   endtask

   task automatic load_ramp();
      for (int i = 0; i < N; i++) frame[i] = DW'((i % 5) * 10);
   endtask

   task automatic load_random();
      for (int i = 0; i < N; i++) frame[i] = DW'($urandom);
   endtask

   initial begin
      #1;
      check_all_zero("reset");
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("ready_before_first_edge", s_ready, 0);
      tick();
      check("ready_after_first_edge", s_ready, 1);

      // Ramp, back to back.
      load_ramp();
      send_frame(1'b0, 1'b0);
      wait_done();
      check("ramp_best_tau_is_5", best_tau, 5);

      // Constant: all zero, tie keeps MIN_TAU.
      for (int i = 0; i < N; i++) frame[i] = DW'(100);
      send_frame(1'b0, 1'b0);
      wait_done();
      check("const_best_tau_is_2", best_tau, 2);

      // Alternating 0/255.
      for (int i = 0; i < N; i++) frame[i] = (i % 2 == 1) ? DW'(255) : DW'(0);
      send_frame(1'b0, 1'b0);
      wait_done();
      check("alt_best_tau_is_2", best_tau, 2);

      // Ramp with random gaps and valid held high through COMPUTE.
      load_ramp();
      send_frame(1'b1, 1'b1);
      wait_done();
      check("gapped_ramp_best_tau_is_5", best_tau, 5);

      // Random data with gaps.
      for (int f = 0; f < 3; f++) begin
         load_random();
         send_frame(1'b1, f[0]);
         wait_done();
      end

      // Reset in the middle of COMPUTE, right when d(4) is presented.
      load_ramp();
      send_frame(1'b0, 1'b0);
      begin
         int c = 0;
         while (!(d_valid && d_tau == TW'(4)) && c < 300) begin
            tick();
            c++;
         end
         if (c >= 300) fail_now("wait_d_tau_4_timeout");
      end
      reset = 1'b0;
      #1;
      check_all_zero("midreset");
      clear_exp();
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("ready_low_at_release", s_ready, 0);
      tick();
      check("ready_one_edge_after_release", s_ready, 1);
      load_ramp();
      send_frame(1'b0, 1'b0);
      wait_done();
      check("post_reset_ramp_best_tau_is_5", best_tau, 5);

      // Flush in FILL together with an accepted sample: sample dropped, index cleared.
      for (int i = 0; i < 10; i++) begin
         s_valid = 1'b1;
         s_data  = DW'($urandom);
         flush   = (i == 9);
         tick();
      end
      flush   = 1'b0;
      s_valid = 1'b0;
      check("fill_flush_busy", busy, 0);
      check("fill_flush_ready", s_ready, 1);
      load_random();
      send_frame(1'b1, 1'b0);
      wait_done();

      // Ramp to set best_tau=5, then flush a random frame mid-COMPUTE.
      load_ramp();
      send_frame(1'b0, 1'b0);
      wait_done();
      load_random();
      send_frame(1'b0, 1'b0);
      repeat (40) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      clear_exp();
      check("flush_busy_low", busy, 0);
      check("flush_ready_high", s_ready, 1);
      repeat (150) tick();
      check("flush_keeps_best_tau", best_tau, 5);
      check("flush_keeps_best_diff", best_diff, 0);
      load_random();
      send_frame(1'b1, 1'b0);
      wait_done();

      check("d_queue_drained", exp_d.size(), 0);
      check("done_queue_drained", exp_done.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/modiff_stream.md
Name: modiff_stream

Overview:
- Streaming successor to the fixed-window modified-difference (MODIFF) pitch engine.
- Accepts unsigned audio samples over a valid/ready handshake into an internal frame buffer.
- Once the buffer is full, sequentially computes d(tau) = sum over n of |x[n] - x[n+tau]| for every tau in [MIN_TAU, MAX_TAU].
- Streams each d(tau) out, then reports the minimising tau. Sits between the sample decimator and the pitch/note estimator.

Parameters:
- DATA_WIDTH, 8: sample width, unsigned.
- WINDOW_SIZE_BITS, 8: window length W = 2^WINDOW_SIZE_BITS.
- MIN_TAU, 2: first lag evaluated; must be >= 1.
- MAX_TAU, 40: last lag evaluated; must be >= MIN_TAU. 40 = 20 ms at FS = 2000.
- TAU_WIDTH, 6: width of lag outputs; must hold MAX_TAU.
- ACC_WIDTH, DATA_WIDTH+WINDOW_SIZE_BITS: d-value width. With MODIFF_SQUARED_EN it is 2*DATA_WIDTH+WINDOW_SIZE_BITS.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-low (reset asserted when 0).
- s_valid  in  1  sample valid.
- s_data  in  DATA_WIDTH  sample.
- s_ready  out  1  block can accept a sample.
- flush  in  1  synchronous abort: discard frame, return to FILL.
- busy  out  1  high in COMPUTE.
- d_valid  out  1  one-cycle pulse, d_tau/d_value valid.
- d_tau  out  TAU_WIDTH  lag of current d_value.
- d_value  out  ACC_WIDTH  d(d_tau).
- done  out  1  one-cycle pulse, frame result valid.
- best_tau  out  TAU_WIDTH  lag with minimum d.
- best_diff  out  ACC_WIDTH  minimum d.

Behaviour:
- Frame buffer depth N = W + MAX_TAU samples. x[0] is the first sample accepted in the frame.
- Reset values, all outputs: s_ready=0, busy=0, d_valid=0, done=0; d_tau, d_value, best_tau, best_diff = 0. State after reset is FILL.
- s_ready is registered. It rises on the first clk edge after reset deasserts.
- FILL:
  - s_ready=1. A sample is accepted on each edge where s_valid && s_ready; write index increments.
  - On acceptance of sample N-1, s_ready drops on the same edge and the state moves to COMPUTE.
  - s_data is ignored when s_ready=0.
- COMPUTE:
  - busy=1. Evaluates tau = MIN_TAU..MAX_TAU ascending, n = 0..W-1, one difference per clock.
  - 2-stage pipeline: read x[n] and x[n+tau], then abs-diff and accumulate.
  - Accumulator clears at n=0 of each tau and never overflows by width rule.
  - Let T0 be the first COMPUTE cycle. d_valid for lag k pulses at cycle T0 + (k-MIN_TAU+1)*W + 1, exactly once per lag, in ascending order.
- Minimum tracking:
  - Running min is initialised from d(MIN_TAU).
  - It is replaced only when d(k) < min, strictly. Ties keep the smaller tau.
- REPORT:
  - Entered the cycle after the last d_valid.
  - done=1 for one cycle; best_tau and best_diff are updated on that same edge.
  - Then returns to FILL with the write index at 0. The previous frame is discarded; frames do not overlap.
- Output hold: best_tau and best_diff hold until the next done. d_tau and d_value hold until the next d_valid.
- Frame latency: total frame compute is (MAX_TAU-MIN_TAU+1)*W + 2 cycles from T0 to done.
- flush:
  - Any state goes to FILL on the next edge. Write index clears; no done or d_valid is produced for the aborted frame.
  - best_* outputs are unchanged.
  - Flush in FILL coincident with an accepted sample: flush wins and the sample is dropped.
- Reset mid-operation: all state and outputs return to reset values immediately. The partial frame is lost.

Optional Feature:
- Macro: MODIFF_SQUARED_EN.
- Defined: the per-sample term is (x[n]-x[n+tau])^2 (true squared-difference/YIN style). Multiplier is placed in pipeline stage 2; latency is unchanged. ACC_WIDTH default is 2*DATA_WIDTH+WINDOW_SIZE_BITS.
- Undefined: absolute difference; no multiplier is inferred.

Test Plan:
- Common setup: WINDOW_SIZE_BITS=4 (W=16), MIN_TAU=2, MAX_TAU=8, N=24.
- Ramp x[i]=(i%5)*10, 24 samples back-to-back -> 7 d_valid pulses; d(5)=0; done with best_tau=5, best_diff=0; done exactly 114 cycles after T0.
- Constant x=100 -> all d(k)=0; tie rule gives best_tau=2, best_diff=0.
- Alternating 0/255 -> d(2)=0, d(3)=4080, d(4)=0; best_tau=2. With MODIFF_SQUARED_EN defined: d(3)=1040400, best_tau=2.
- Backpressure: s_valid toggling 1/0 randomly, plus s_valid held high through COMPUTE -> exactly 24 samples accepted; s_ready=0 while busy=1; results identical to back-to-back run.
- reset driven to 0 at d_tau=4 in COMPUTE -> all outputs 0 immediately; s_ready=1 one edge after release; the next full frame of the ramp yields best_tau=5.
- flush pulsed mid-COMPUTE -> no done; best_tau keeps its previous value (5); the next frame completes normally.
